fetch_stage: RTL
================

Name: fetch_stage

Overview:
Instruction-fetch stage directly upstream of the main decode controller. It holds the PC, issues requests to instruction memory over a req/ack handshake, and buffers returned words in an IF/ID register plus a one-entry skid buffer. It presents op/func fields to the controller and supports a downstream stall and a branch/jump redirect with flush.

Parameters:
- ADDR_W, 32, PC and imem address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- imem_req, output, 1, fetch request.
- imem_addr, output, ADDR_W, word-aligned fetch address.
- imem_ack, input, 1, one-cycle response strobe; imem_rdata valid in the same cycle.
- imem_rdata, input, 32, fetched instruction.
- stall, input, 1, downstream cannot accept a new instruction this cycle.
- redirect, input, 1, load redirect_pc and flush.
- redirect_pc, input, ADDR_W, new PC; bits [1:0] ignored and forced to 0.
- valid_out, output, 1, IF/ID register holds a valid instruction.
- instr_out, output, 32, IF/ID instruction.
- pc_out, output, ADDR_W, PC of instr_out.
- op, output, 6, instr_out[31:26]; 0 when valid_out=0.
- func, output, 6, instr_out[5:0]; 0 when valid_out=0.

Behaviour:
- Reset values: pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC; valid_out=0; instr_out=0; pc_out=0; skid empty.
- Slot free means `!valid_out || !stall`.
- IDLE: a single cycle after reset deasserts. Go to REQ.
- REQ:
  - imem_req=1 and imem_addr=pc. Both are held stable until ack.
  - On ack with slot free: next cycle instr_out=imem_rdata, pc_out=pc, valid_out=1, and pc=pc+4. Stay in REQ, so back-to-back fetch gives one instruction per cycle when ack is immediate.
  - On ack without slot free: the word and its PC go into the skid buffer, pc=pc+4, and the state goes to HOLD.
- HOLD:
  - imem_req=0.
  - When stall=0, the skid entry moves into IF/ID (valid_out=1), the skid empties, and the state goes to REQ.
- Stall without ack: IF/ID holds its contents unchanged. imem_req stays asserted so the handshake is not broken.
- Slot free with no capture: when valid_out=1, stall=0 and there is no ack, valid_out goes to 0 next cycle (bubble).
- Redirect has priority over every other event in the same cycle:
  - pc=redirect_pc & ~3, valid_out=0, and the skid is cleared.
  - Redirect in REQ with no ack that cycle: go to DROP. In DROP, imem_req is held at the old address until ack; that response is discarded, then the state goes to REQ with the new pc.
  - Redirect in REQ with ack in the same cycle: the response is discarded and the state goes to REQ with the new pc.
  - Redirect in IDLE or HOLD: go to REQ.
  - Redirect in DROP: update the target pc and stay in DROP.
- PC arithmetic is modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-transaction abandons any pending ack. The memory side must tolerate a dropped req.
- instr_out changes only on capture, skid transfer, or reset. valid_out=0 forces op/func to 0, which the controller decodes as no-op.

Optional Feature:
- Macro: FETCH_PERF_EN.
- With the macro defined: adds output ports perf_fetch_cnt[31:0] and perf_stall_cnt[31:0], both reset to 0. perf_fetch_cnt increments on every accepted ack, excluding discarded ones. perf_stall_cnt increments each cycle with valid_out=1 and stall=1. Both wrap at 2^32.
- Without the macro: the ports and counters are absent. Functional behaviour is otherwise identical.

Decomposition:
- Package mips_pkg:
  - INSTR_W=32.
  - OP_MSB/OP_LSB=31/26.
  - FUNC_MSB/FUNC_LSB=5/0.
  - PC_INCR=4.
  - Fetch state encoding: IDLE, REQ, HOLD, DROP.
- Sub-module fetch_skid_buf: the one-entry instruction+PC buffer with load, unload and clear.

Test Plan:
- Reset, then ack every cycle with rdata=32'h0000_0020 and stall=0 -> imem_addr sequence 0,4,8. valid_out=1 from the cycle after the first ack. op=0, func=6'h20, pc_out=0,4,8.
- Valid_out=1, assert stall for 3 cycles with ack at addr 8 -> the ack is captured in skid and the state enters HOLD with imem_req=0. instr_out is unchanged. After stall drops, instr_out is the addr 8 word with pc_out=8, and the next request is at 12.
- In REQ at pc=16, ack delayed 2 cycles, redirect=1 with redirect_pc=32'h0000_0103 in the first cycle -> the 16 response is discarded and valid_out=0. The next request is at 32'h0000_0100.
- Redirect and ack in the same cycle -> rdata is discarded. The next imem_addr is the redirect target and valid_out=0 next cycle.
- pc=32'hFFFF_FFFC, ack -> next imem_addr=0.
- With FETCH_PERF_EN: 5 accepted fetches, 1 discarded, 3 stall cycles with valid_out=1 -> perf_fetch_cnt=5 and perf_stall_cnt=3. Reset clears both.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants and the fetch state type for the instruction-fetch front end.
//   INSTR_W           : instruction word width
//   OP_MSB / OP_LSB   : opcode field position within an instruction
//   FUNC_MSB/FUNC_LSB : function field position within an instruction
//   PC_INCR           : byte increment between sequential fetches
//   fetch_state_e     : IDLE, REQ, HOLD, DROP
package mips_pkg;

    localparam int INSTR_W  = 32;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 26;
    localparam int FUNC_MSB = 5;
    localparam int FUNC_LSB = 0;
    localparam int PC_INCR  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf
// One-entry holding slot for a fetched word and its PC. It catches a memory
// response that arrives while the IF/ID register is still stalled.
// Ports:
//   clk, reset         : clock, synchronous active-high reset
//   load_i             : capture instr_i/pc_i and mark the entry full
//   unload_i           : mark the entry empty (its contents have been consumed)
//   clear_i            : discard the entry; wins over load_i and unload_i
//   instr_i, pc_i      : word and PC to capture
//   valid_o            : entry is full
//   instr_o, pc_o      : stored word and PC
module fetch_skid_buf
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic                unload_i,
    input  logic                clear_i,
    input  logic [INSTR_W-1:0]  instr_i,
    input  logic [ADDR_W-1:0]   pc_i,
    output logic                valid_o,
    output logic [INSTR_W-1:0]  instr_o,
    output logic [ADDR_W-1:0]   pc_o
);

    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (clear_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (unload_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake,
// buffers words in the IF/ID register plus a one-entry skid buffer, and
// exposes op/func to the decode controller. Supports stall and redirect/flush.
// Optional macro FETCH_PERF_EN adds perf_fetch_cnt / perf_stall_cnt.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   imem_req, imem_addr     : fetch request and word-aligned address
//   imem_ack, imem_rdata    : one-cycle response strobe and its data
//   stall                   : downstream cannot accept this cycle
//   redirect, redirect_pc   : load new PC (low two bits dropped) and flush
//   valid_out, instr_out,
//   pc_out                  : IF/ID register contents
//   op, func                : decoded fields, zero while valid_out is low
//
// state | meaning
// IDLE  | one cycle after reset, nothing outstanding
// REQ   | request at pc outstanding
// HOLD  | response parked in skid, waiting for stall to drop, no request
// DROP  | request at a pre-redirect address outstanding, response discarded
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
)(
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic                imem_ack,
    input  logic [INSTR_W-1:0]  imem_rdata,
    input  logic                stall,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                valid_out,
    output logic [INSTR_W-1:0]  instr_out,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [5:0]          op,
    output logic [5:0]          func
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;
    logic               valid_q, valid_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;

    logic               slot_free;
    logic               fetch_accept;
    logic               skid_load, skid_unload, skid_clear;
    logic               skid_valid;
    logic [INSTR_W-1:0] skid_instr;
    logic [ADDR_W-1:0]  skid_pc;
    logic [ADDR_W-1:0]  redirect_al;

    assign slot_free   = !valid_q || !stall;
    assign redirect_al = redirect_pc & ~ADDR_W'(3);

    // DROP keeps presenting the abandoned address so the handshake completes.
    assign imem_req  = (state_q == REQ) || (state_q == DROP);
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        skid_load    = 1'b0;
        skid_unload  = 1'b0;
        skid_clear   = 1'b0;
        fetch_accept = 1'b0;

        if (redirect) begin
            pc_d       = redirect_al;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            unique case (state_q)
                REQ: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end else begin
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end
                DROP:    state_d = DROP;
                default: state_d = REQ;
            endcase
        end else begin
            // Consumed with nothing to replace it: bubble.
            if (valid_q && !stall) begin
                valid_d = 1'b0;
            end
            unique case (state_q)
                IDLE: state_d = REQ;
                REQ: begin
                    if (imem_ack) begin
                        fetch_accept = 1'b1;
                        pc_d         = pc_q + ADDR_W'(PC_INCR);
                        if (slot_free) begin
                            valid_d  = 1'b1;
                            instr_d  = imem_rdata;
                            pc_out_d = pc_q;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        if (skid_valid) begin
                            valid_d  = 1'b1;
                            instr_d  = skid_instr;
                            pc_out_d = skid_pc;
                        end
                        skid_unload = 1'b1;
                        state_d     = REQ;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        state_d = REQ;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            drop_addr_q <= RESET_PC;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            pc_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            pc_out_q    <= pc_out_d;
        end
    end

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (skid_clear),
        .instr_i  (imem_rdata),
        .pc_i     (pc_q),
        .valid_o  (skid_valid),
        .instr_o  (skid_instr),
        .pc_o     (skid_pc)
    );

    assign valid_out = valid_q;
    assign instr_out = instr_q;
    assign pc_out    = pc_out_q;
    assign op        = valid_q ? instr_q[OP_MSB:OP_LSB]     : 6'd0;
    assign func      = valid_q ? instr_q[FUNC_MSB:FUNC_LSB] : 6'd0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (fetch_accept) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (valid_q && stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    // Accepted-fetch strobe only feeds the optional counters.
    logic unused_fetch_accept;
    assign unused_fetch_accept = fetch_accept;
`endif

endmodule
